uart_hex_reporter: RTL and testbench
====================================

Name: uart_hex_reporter

Overview:
- Transmit-side companion to the UART loopback/verification circuit.
- On a one-cycle start tick, it captures an 8-bit value and formats it as an ASCII hex message, e.g. "0xA5\r\n".
- It pushes the message byte by byte into the uart_top transmit FIFO through the write_uart/write_data/tx_full handshake.
- Typical uses: report switch values, received bytes or status registers to the PC terminal.

Parameters:
- PREFIX_EN, 1: 1 = prepend "0x" (0x30, 0x78); 0 = no prefix.
- UPPERCASE, 1: 1 = hex letters 'A'-'F' (0x41-0x46); 0 = 'a'-'f' (0x61-0x66).
- EOL_MODE, 2: 0 = no terminator; 1 = LF (0x0A); 2 = CR LF (0x0D, 0x0A).

Ports:
- CLK  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request tick (e.g. debounced db_tick); ignored unless idle.
- data_in  in  8  value to report; sampled only on an accepted start.
- tx_full  in  1  uart_top TX FIFO full flag.
- write_uart  out  1  one-cycle FIFO write strobe; registered.
- write_data  out  8  ASCII byte; registered, valid while write_uart=1.
- busy  out  1  high from the cycle after an accepted start until the message completes.
- done  out  1  one-cycle pulse after the last byte is written; registered.

Behaviour:
- One clock domain (CLK). Reset is synchronous, active-high.
- Reset values: write_uart=0, write_data=8'h00, done=0, busy=0, state=IDLE, byte index=0, latched data=0.
- Message length LEN = 2 + 2*PREFIX_EN + EOL_MODE, giving a range of 2..6 bytes.
- Byte order:
  - [prefix '0','x']
  - high-nibble hex char
  - low-nibble hex char
  - [CR] LF per EOL_MODE
- Nibble to ASCII: 0-9 map to 0x30+n; 10-15 map to 0x41+n-10 if UPPERCASE, otherwise 0x61+n-10.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - done=0.
  - If start=1: latch data_in, index=0, go to SEND.
- SEND:
  - If tx_full=1: stay in SEND, write_uart=0, no write; write_data holds its last value.
  - If tx_full=0: next cycle write_uart=1, write_data=char[index], index++, go to GAP.
- GAP:
  - write_uart returns to 0. This guarantees at most one write every 2 cycles, so tx_full reflects the previous write before the next decision.
  - If index==LEN: done=1 for one cycle, go to IDLE.
  - Otherwise go to SEND.
- busy = (state != IDLE), decoded from the state register.
- Timing, tx_full low, start high in cycle 0:
  - write_uart high in cycles 2, 4, …, 2*LEN.
  - done high in cycle 2*LEN+1; busy high in cycles 1..2*LEN.
  - A new start is accepted in cycle 2*LEN+1.
- Start while busy: ignored and not queued; data_in changes while busy have no effect.
- Simultaneous done and start in the same cycle: start is accepted, since the FSM is in IDLE.
- tx_full asserting mid-message: the FSM stalls in SEND indefinitely with no byte loss or duplication, and resumes in order on deassertion.
- Reset mid-message: the next cycle is in reset state; no further writes and no done pulse. Bytes already written stay in the FIFO.
- write_uart is never high for 2 consecutive cycles, and never high while the FSM decided under tx_full=1.

Test Plan:
- Default params, data_in=0xA5, start at cycle 0, tx_full=0 → write_data 30 78 41 35 0D 0A on cycles 2, 4, 6, 8, 10, 12; done at cycle 13; busy high cycles 1-12.
- UPPERCASE=0, PREFIX_EN=0, EOL_MODE=1, data_in=0x3F → bytes 33 66 0A on cycles 2, 4, 6; done at cycle 7.
- data_in=0x09, tx_full forced high cycles 5-20 → writes 30 78 before the stall; no write_uart during cycles 5-21; remaining 30 39 0D 0A follow after release; exactly 6 writes total.
- Second start pulses at cycles 3 and 8, with data_in changed to 0xFF, during a 0x12 message → only "0x12\r\n" is sent; one done pulse.
- reset asserted at cycle 7 of a message → next cycle all outputs 0, busy=0, no further writes; a new start then sends a complete message from byte 0.
- Back-to-back: start re-asserted in the done cycle → second message begins with no gap beyond the normal 1-cycle accept; both messages are complete.

Source files
------------

// File: rtl/uart_hex_reporter.sv
// uart_hex_reporter: formats a captured byte as ASCII hex ("0xA5\r\n") and pushes it
// into the UART TX FIFO one byte every two cycles, stalling while the FIFO is full.
module uart_hex_reporter #(
    parameter bit          PREFIX_EN = 1'b1,
    parameter bit          UPPERCASE = 1'b1,
    parameter int unsigned EOL_MODE  = 2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       tx_full,
    output logic       write_uart,
    output logic [7:0] write_data,
    output logic       busy,
    output logic       done
);
    localparam logic [2:0] PRE3 = PREFIX_EN ? 3'd2 : 3'd0;
    localparam logic [2:0] LEN3 = 3'(2 + (PREFIX_EN ? 2 : 0) + EOL_MODE);
    localparam bit         CRLF = (EOL_MODE == 2);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic       wr_q, wr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       done_q, done_d;
    logic [7:0] char_c;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, n};
    endfunction

    always_comb begin
        char_c = (PREFIX_EN && idx_q[2:1] == 2'b00) ? (idx_q[0] ? 8'h78 : 8'h30) :
                 (idx_q == PRE3)                     ? hex_char(data_q[7:4]) :
                 (idx_q == PRE3 + 3'd1)              ? hex_char(data_q[3:0]) :
                 (CRLF && idx_q == PRE3 + 3'd2)      ? 8'h0D : 8'h0A;
    end

    // GAP between writes lets tx_full reflect the previous push before the next decision
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                data_d  = data_in;
                idx_d   = 3'd0;
                state_d = SEND;
            end
            SEND: if (!tx_full) begin
                wr_d    = 1'b1;
                wdata_d = char_c;
                idx_d   = idx_q + 3'd1;
                state_d = GAP;
            end
            GAP: begin
                done_d  = (idx_q == LEN3);
                state_d = (idx_q == LEN3) ? IDLE : SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            data_q  <= 8'h00;
            wr_q    <= 1'b0;
            wdata_q <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign write_uart = wr_q;
    assign write_data = wdata_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_hex_reporter.sv
// tb_uart_hex_reporter: directed scenarios on the default configuration and on a
// lowercase / no-prefix / LF-only instance, with hand-computed byte streams.
module tb_uart_hex_reporter;
    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       tx_full = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       start2 = 1'b0;
    logic [7:0] data2 = 8'h00;
    logic       write_uart, busy, done;
    logic [7:0] write_data;
    logic       wr2, busy2, done2;
    logic [7:0] wd2;
    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    uart_hex_reporter dut (
        .CLK(CLK), .reset(reset), .start(start), .data_in(data_in), .tx_full(tx_full),
        .write_uart(write_uart), .write_data(write_data), .busy(busy), .done(done)
    );

    uart_hex_reporter #(.PREFIX_EN(1'b0), .UPPERCASE(1'b0), .EOL_MODE(1)) dut2 (
        .CLK(CLK), .reset(reset), .start(start2), .data_in(data2), .tx_full(1'b0),
        .write_uart(wr2), .write_data(wd2), .busy(busy2), .done(done2)
    );

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        data_in = 8'hFF;
        repeat (3) @(posedge CLK);
        #1 start = 1'b0;
        @(negedge CLK);
        total++; if (write_uart !== 1'b0) begin bad++; $display("FAIL reset_wr got=%b exp=0", write_uart); end
        total++; if (write_data !== 8'h00) begin bad++; $display("FAIL reset_wd got=%h exp=00", write_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if ({wr2, wd2, busy2, done2} !== 11'h0) begin bad++; $display("FAIL reset_dut2 got=%h exp=0", {wr2, wd2, busy2, done2}); end
        @(posedge CLK);
        #1 reset = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_default();
        logic [7:0] eb [6];
        int nw = 0;
        eb = '{8'h30, 8'h78, 8'h41, 8'h35, 8'h0D, 8'h0A};
        for (int c = 0; c < 16; c++) begin
            start = (c == 0);
            data_in = 8'hA5;
            @(negedge CLK);
            total++; if (busy !== (c >= 1 && c <= 12)) begin bad++; $display("FAIL default_busy c=%0d got=%b", c, busy); end
            total++; if (done !== (c == 13)) begin bad++; $display("FAIL default_done c=%0d got=%b", c, done); end
            total++; if (write_uart !== (c >= 2 && c <= 12 && c % 2 == 0)) begin bad++; $display("FAIL default_wr c=%0d got=%b", c, write_uart); end
            if (write_uart === 1'b1 && nw < 6) begin
                total++; if (write_data !== eb[nw]) begin bad++; $display("FAIL default_byte%0d got=%h exp=%h", nw, write_data, eb[nw]); end
                nw++;
            end
            @(posedge CLK);
            #1;
        end
        total++; if (nw != 6) begin bad++; $display("FAIL default_count got=%0d exp=6", nw); end
    endtask

    task automatic test_lower();
        logic [7:0] eb [3];
        int nw = 0;
        eb = '{8'h33, 8'h66, 8'h0A};
        for (int c = 0; c < 10; c++) begin
            start2 = (c == 0);
            data2 = 8'h3F;
            @(negedge CLK);
            total++; if (busy2 !== (c >= 1 && c <= 6)) begin bad++; $display("FAIL lower_busy c=%0d got=%b", c, busy2); end
            total++; if (done2 !== (c == 7)) begin bad++; $display("FAIL lower_done c=%0d got=%b", c, done2); end
            total++; if (wr2 !== (c >= 2 && c <= 6 && c % 2 == 0)) begin bad++; $display("FAIL lower_wr c=%0d got=%b", c, wr2); end
            if (wr2 === 1'b1 && nw < 3) begin
                total++; if (wd2 !== eb[nw]) begin bad++; $display("FAIL lower_byte%0d got=%h exp=%h", nw, wd2, eb[nw]); end
                nw++;
            end
            @(posedge CLK);
            #1;
        end
        total++; if (nw != 3) begin bad++; $display("FAIL lower_count got=%0d exp=3", nw); end
    endtask

    task automatic test_stall();
        logic [7:0] eb [6];
        int wc [6];
        int nw = 0;
        eb = '{8'h30, 8'h78, 8'h30, 8'h39, 8'h0D, 8'h0A};
        wc = '{2, 4, 22, 24, 26, 28};
        for (int c = 0; c < 33; c++) begin
            start = (c == 0);
            data_in = 8'h09;
            tx_full = (c >= 5 && c <= 20);
            @(negedge CLK);
            if (write_uart === 1'b1) begin
                total++;
                if (nw >= 6 || c != wc[nw] || write_data !== eb[nw]) begin
                    bad++; $display("FAIL stall_write n=%0d c=%0d got=%h", nw, c, write_data);
                end
                nw++;
            end
            total++; if (done !== (c == 29)) begin bad++; $display("FAIL stall_done c=%0d got=%b", c, done); end
            @(posedge CLK);
            #1;
        end
        tx_full = 1'b0;
        total++; if (nw != 6) begin bad++; $display("FAIL stall_count got=%0d exp=6", nw); end
    endtask

    task automatic test_ignore_start();
        logic [7:0] eb [6];
        int nw = 0;
        eb = '{8'h30, 8'h78, 8'h31, 8'h32, 8'h0D, 8'h0A};
        for (int c = 0; c < 22; c++) begin
            start = (c == 0 || c == 3 || c == 8);
            data_in = (c < 3) ? 8'h12 : 8'hFF;
            @(negedge CLK);
            total++; if (write_uart !== (c >= 2 && c <= 12 && c % 2 == 0)) begin bad++; $display("FAIL ignore_wr c=%0d got=%b", c, write_uart); end
            if (write_uart === 1'b1 && nw < 6) begin
                total++; if (write_data !== eb[nw]) begin bad++; $display("FAIL ignore_byte%0d got=%h exp=%h", nw, write_data, eb[nw]); end
                nw++;
            end
            total++; if (done !== (c == 13)) begin bad++; $display("FAIL ignore_done c=%0d got=%b", c, done); end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] eb [6];
        int nw = 0;
        eb = '{8'h30, 8'h78, 8'h35, 8'h43, 8'h0D, 8'h0A};
        for (int c = 0; c < 20; c++) begin
            start = (c == 0);
            data_in = 8'h5C;
            reset = (c == 7);
            @(negedge CLK);
            total++; if (write_uart !== (c >= 2 && c <= 6 && c % 2 == 0)) begin bad++; $display("FAIL rstmid_wr c=%0d got=%b", c, write_uart); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL rstmid_done c=%0d got=%b", c, done); end
            if (c == 8) begin
                total++; if ({write_data, busy} !== 9'h0) begin bad++; $display("FAIL rstmid_clear got=%h exp=0", {write_data, busy}); end
            end
            @(posedge CLK);
            #1;
        end
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            start = (c == 0);
            @(negedge CLK);
            if (write_uart === 1'b1) begin
                total++; if (nw >= 6 || c != 2 * nw + 2 || write_data !== eb[nw]) begin bad++; $display("FAIL rstmid_resend n=%0d c=%0d got=%h", nw, c, write_data); end
                nw++;
            end
            total++; if (done !== (c == 13)) begin bad++; $display("FAIL rstmid_done2 c=%0d got=%b", c, done); end
            @(posedge CLK);
            #1;
        end
        total++; if (nw != 6) begin bad++; $display("FAIL rstmid_count got=%0d exp=6", nw); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] eb [12];
        int nw = 0;
        int wc;
        eb = '{8'h30, 8'h78, 8'h33, 8'h43, 8'h0D, 8'h0A, 8'h30, 8'h78, 8'h37, 8'h45, 8'h0D, 8'h0A};
        for (int c = 0; c < 30; c++) begin
            start = (c == 0 || c == 13);
            data_in = (c < 13) ? 8'h3C : 8'h7E;
            @(negedge CLK);
            if (write_uart === 1'b1) begin
                wc = (nw < 6) ? 2 * nw + 2 : 2 * (nw - 6) + 15;
                total++; if (nw >= 12 || c != wc || write_data !== eb[nw]) begin bad++; $display("FAIL b2b_write n=%0d c=%0d got=%h", nw, c, write_data); end
                nw++;
            end
            total++; if (done !== (c == 13 || c == 26)) begin bad++; $display("FAIL b2b_done c=%0d got=%b", c, done); end
            if (c == 14) begin
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
            end
            @(posedge CLK);
            #1;
        end
        start = 1'b0;
        total++; if (nw != 12) begin bad++; $display("FAIL b2b_count got=%0d exp=12", nw); end
    endtask

    initial begin
        test_reset();
        test_default();
        test_lower();
        test_stall();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
